// File: rtl/riscv_instr_encoder.sv
// riscv_instr_encoder: two-stage RV32 instruction encoder.
// S1 captures the decoded fields and judges legality. S2 holds the encoded
// word and presents it with a sequential word address.
// Optional macro RISCV_ENC_RANGE_CHECK_EN: when defined, immediates that do
// not fit their format (or are misaligned) are dropped with an err pulse.
// When undefined, only fmt 6/7 is dropped, and other immediates are truncated.
module riscv_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

    // S1 entry
    logic        r_s1_valid;
    logic [2:0]  r_s1_fmt;
    logic [6:0]  r_s1_opcode;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [2:0]  r_s1_funct3;
    logic [6:0]  r_s1_funct7;
    logic [31:0] r_s1_imm;

    // S2 entry and output-side state
    logic              r_s2_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [7:0]        r_err_cnt;

    logic        w_range_ok;
    logic        w_s1_legal;
    logic        w_s2_load;
    logic        w_s1_adv;
    logic        w_s1_move;
    logic        w_accept;
    logic        w_out_fire;
    logic        w_err;
    logic [31:0] w_enc;

    // Immediate range/alignment check for the entry held in S1
    always_comb begin
        // NOTE: default first so every path assigns it; otherwise a latch is inferred.
        w_range_ok = 1'b1;
`ifdef RISCV_ENC_RANGE_CHECK_EN
        case (r_s1_fmt)
            FMT_I, FMT_S: w_range_ok = (&r_s1_imm[31:11]) | ~(|r_s1_imm[31:11]);
            FMT_B:        w_range_ok = ((&r_s1_imm[31:12]) | ~(|r_s1_imm[31:12])) & ~r_s1_imm[0];
            FMT_J:        w_range_ok = ((&r_s1_imm[31:20]) | ~(|r_s1_imm[31:20])) & ~r_s1_imm[0];
            FMT_U:        w_range_ok = ~(|r_s1_imm[11:0]);
            default:      w_range_ok = 1'b1;
        endcase
`endif
    end

    assign w_s1_legal = (r_s1_fmt <= FMT_J) & w_range_ok;

    // Pipeline flow: S2 refills when empty or draining; an illegal S1 entry always leaves
    assign w_s2_load  = ~r_s2_valid | out_ready;
    assign w_s1_adv   = r_s1_valid & (w_s2_load | ~w_s1_legal);
    assign w_s1_move  = r_s1_valid & w_s1_legal;
    assign in_ready   = ~clear & (~r_s1_valid | w_s1_adv);
    assign w_accept   = in_valid & in_ready;
    assign w_out_fire = r_s2_valid & out_ready;
    assign w_err      = r_s1_valid & ~w_s1_legal & ~clear;

    // Scatter S1 fields into the instruction word by format
    always_comb begin
        w_enc = 32'd0;
        case (r_s1_fmt)
            FMT_R: w_enc = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            FMT_I: w_enc = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            FMT_S: w_enc = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                            r_s1_imm[4:0], r_s1_opcode};
            FMT_B: w_enc = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                            r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
            FMT_U: w_enc = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
            FMT_J: w_enc = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                            r_s1_rd, r_s1_opcode};
            default: w_enc = 32'd0;
        endcase
    end

    // S1 occupancy: fill on accept, empty when the entry leaves or on clear
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S1 field capture
    // NOTE: payload flops carry no reset; r_s1_valid qualifies them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_fmt    <= fmt;
            r_s1_opcode <= opcode;
            r_s1_rd     <= rd;
            r_s1_rs1    <= rs1;
            r_s1_rs2    <= rs2;
            r_s1_funct3 <= funct3;
            r_s1_funct7 <= funct7;
            r_s1_imm    <= imm;
        end
    end

    // S2 output register: loads the encoded word when a legal S1 entry moves up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_out_instr <= 32'd0;
        end else if (clear) begin
            r_s2_valid  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= w_s1_move;
            if (w_s1_move) begin
                r_out_instr <= w_enc;
            end
        end
    end

    // Word address: advances on each output handshake, restarts on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_addr <= L_BASE;
        end else if (clear) begin
            r_out_addr <= L_BASE;
        end else if (w_out_fire) begin
            r_out_addr <= r_out_addr + 1'b1;
        end
    end

    // Saturating count of dropped requests; survives clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err       = w_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Testbench for riscv_instr_encoder (ADDR_W=2, BASE_ADDR=2 so wrap and base
// restart are both visible). A scoreboard queue fed by accepted requests is
// compared against every emitted word; err/err_cnt are predicted each cycle.
module tb_riscv_instr_encoder;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        fmt = 3'd0;
    logic [6:0]        opcode = 7'd0;
    logic [4:0]        rd = 5'd0;
    logic [4:0]        rs1 = 5'd0;
    logic [4:0]        rs2 = 5'd0;
    logic [2:0]        funct3 = 3'd0;
    logic [6:0]        funct7 = 7'd0;
    logic [31:0]       imm = 32'd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_cnt;

    riscv_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from field positions with shifts and masks
    function automatic logic [31:0] model_encode(input logic [2:0] f, input logic [6:0] op,
            input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        int unsigned uop, ud, ua, ub, uf3, uf7, ui;
        uop = op; ud = d; ua = a; ub = b; uf3 = f3; uf7 = f7; ui = im;
        case (f)
            3'd0: return (uf7 << 25) | (ub << 20) | (ua << 15) | (uf3 << 12) | (ud << 7) | uop;
            3'd1: return ((ui & 32'hFFF) << 20) | (ua << 15) | (uf3 << 12) | (ud << 7) | uop;
            3'd2: return (((ui >> 5) & 127) << 25) | (ub << 20) | (ua << 15) | (uf3 << 12)
                         | ((ui & 31) << 7) | uop;
            3'd3: return (((ui >> 12) & 1) << 31) | (((ui >> 5) & 63) << 25) | (ub << 20)
                         | (ua << 15) | (uf3 << 12) | (((ui >> 1) & 15) << 8)
                         | (((ui >> 11) & 1) << 7) | uop;
            3'd4: return (ui & 32'hFFFF_F000) | (ud << 7) | uop;
            3'd5: return (((ui >> 20) & 1) << 31) | (((ui >> 1) & 1023) << 21)
                         | (((ui >> 11) & 1) << 20) | (((ui >> 12) & 255) << 12)
                         | (ud << 7) | uop;
            default: return 32'd0;
        endcase
    endfunction

    // Reference legality from signed value ranges and alignment
    function automatic bit model_legal(input logic [2:0] f, input logic [31:0] im);
        int s;
        s = $signed(im);
        if (f > 3'd5) return 1'b0;
`ifdef RISCV_ENC_RANGE_CHECK_EN
        case (f)
            3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
            3'd3:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            3'd4:       return (im % 4096) == 0;
            3'd5:       return (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
            default:    return 1'b1;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    // Scoreboard state
    logic [31:0]       q_instr[$];
    logic [ADDR_W-1:0] exp_addr = ADDR_W'(BASE_ADDR);
    int                exp_cnt = 0;
    bit                err_due = 1'b0;
    int                n_pops = 0;

    // Compare process: checks outputs on the falling edge, then advances the model
    always @(negedge clk) begin
        if (!rst_n) begin
            q_instr.delete();
            exp_addr = ADDR_W'(BASE_ADDR);
            exp_cnt  = 0;
            err_due  = 1'b0;
        end else begin
            check("err", {31'd0, err}, {31'd0, err_due && !clear});
            check("err_cnt", {24'd0, err_cnt}, exp_cnt);
            if (clear) check("in_ready_during_clear", {31'd0, in_ready}, 32'd0);
            if (out_valid) begin
                if (q_instr.size() == 0) begin
                    check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("out_instr", out_instr, q_instr[0]);
                    check("out_addr", {30'd0, out_addr}, {30'd0, exp_addr});
                end
            end
            if (clear) begin
                q_instr.delete();
                exp_addr = ADDR_W'(BASE_ADDR);
                err_due  = 1'b0;
            end else begin
                if (err_due && exp_cnt < 255) exp_cnt++;
                err_due = 1'b0;
                if (out_valid && out_ready && q_instr.size() > 0) begin
                    void'(q_instr.pop_front());
                    exp_addr = exp_addr + 1'b1;
                    n_pops++;
                end
                if (in_valid && in_ready) begin
                    if (model_legal(fmt, imm))
                        q_instr.push_back(model_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
                    else
                        err_due = 1'b1;
                end
            end
        end
    end

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
            input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
            input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Present one request and hold it until accepted; returns 1 time unit after the accepting edge
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
            input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
            input logic [6:0] f7, input logic [31:0] im);
        set_req(f, op, d, a, b, f3, f7, im);
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 20; k++) begin
            if (out_valid) return;
            @(posedge clk);
            #1;
        end
        check("wait_out_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (q_instr.size() == 0 && !out_valid) break;
        end
        check("drain_queue_empty", q_instr.size(), 32'd0);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_acc;
    int idx;
    int pops0;
    bit acc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", {30'd0, out_addr}, 32'd2);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        // addi x1, x0, 5 with two-stage latency
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        check("addi_latency_s1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("addi_latency_s2", {31'd0, out_valid}, 32'd1);
        check("addi_instr", out_instr, 32'h0050_0093);
        check("addi_addr", {30'd0, out_addr}, 32'd2);

        // beq x1, x2, -4 then jal x1, 8 at the following addresses (3, then wrap to 0)
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        wait_out();
        check("beq_instr", out_instr, 32'hFE20_8EE3);
        check("beq_addr", {30'd0, out_addr}, 32'd3);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        wait_out();
        check("jal_instr", out_instr, 32'h0080_00EF);
        check("jal_addr", {30'd0, out_addr}, 32'd0);
        wait_drain();

        // I-type immediate 0x800 is out of range
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
`ifdef RISCV_ENC_RANGE_CHECK_EN
        check("range_err_pulse", {31'd0, err}, 32'd1);
        @(posedge clk);
        #1;
        check("range_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("range_no_output", {31'd0, out_valid}, 32'd0);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        wait_out();
        check("range_next_addr", {30'd0, out_addr}, 32'd1);
`else
        wait_out();
        check("trunc_instr", out_instr, 32'h8000_0093);
        check("trunc_addr", {30'd0, out_addr}, 32'd1);
        check("trunc_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        wait_drain();

        // Backpressure: stall for 6 cycles while 4 requests are offered
        out_ready = 1'b0;
        pops0 = n_pops;
        idx = 0;
        n_acc = 0;
        set_req(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            if (c == 6) begin
                check("bp_accepted_under_stall", n_acc, 32'd2);
                out_ready = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                n_acc++;
                idx++;
                if (idx < 4) set_req(3'd0, 7'h33, 5'(idx + 1), 5'(idx + 2), 5'(idx + 3), 3'(idx), 7'(idx), 32'd0);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("bp_words_out", n_pops - pops0, 32'd4);

        // Clear with two words buffered
        out_ready = 1'b0;
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        send(3'd4, 7'h17, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
        check("clear_pre_full", {31'd0, out_valid}, 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        send(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'hFFFF_FFF8);
        wait_out();
        check("clear_next_addr", {30'd0, out_addr}, 32'd2);
        check("clear_next_instr", out_instr, 32'hFE41_AC23);
        wait_drain();

        // Saturation of err_cnt with illegal formats
        for (int k = 0; k < 260; k++) send(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            clear     = ($urandom % 64) == 0;
            fmt    = 3'($urandom_range(0, 7));
            opcode = 7'($urandom);
            rd     = 5'($urandom);
            rs1    = 5'($urandom);
            rs2    = 5'($urandom);
            funct3 = 3'($urandom);
            funct7 = 7'($urandom);
            case ($urandom % 4)
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd1, 7'd0, 32'd7);
        send(3'd1, 7'h13, 5'd4, 5'd5, 5'd0, 3'd1, 7'd0, 32'd9);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("async_rst_out_addr", {30'd0, out_addr}, 32'd2);
        check("async_rst_out_instr", out_instr, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        wait_out();
        check("post_rst_addr", {30'd0, out_addr}, 32'd2);
        check("post_rst_instr", out_instr, 32'h0050_0093);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
